// File: rtl/button_pkg.sv
// Shared constants for the push-button conditioning stage: per-channel FSM
// encoding and the default debounce interval for a 100 MHz system clock.
package button_pkg;

  localparam logic [1:0] IDLE_LOW  = 2'b00;
  localparam logic [1:0] WAIT_HIGH = 2'b01;
  localparam logic [1:0] IDLE_HIGH = 2'b11;
  localparam logic [1:0] WAIT_LOW  = 2'b10;

  // 10 ms at 100 MHz
  localparam int DEBOUNCE_100MHZ = 1_000_000;

endpackage

// File: rtl/debounce_channel.sv
// One button channel: two-flop synchronizer, debounce FSM with stability
// counter, and registered level / rise / fall outputs.
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync;
  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic             w_level_nxt;
  logic             w_rise_nxt;
  logic             w_fall_nxt;

  // Bring the asynchronous raw level into the clk domain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync  <= 1'b0;
    end else begin
      r_sync1 <= i_raw;
      r_sync  <= r_sync1;
    end
  end

  // FSM state and stability counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE_LOW;
      r_cnt   <= {CNT_W{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state: a WAIT state abandons on the first disagreeing sample.
  always_comb begin
    w_state_nxt = IDLE_LOW;
    w_cnt_nxt   = {CNT_W{1'b0}};
    case (r_state)
      IDLE_LOW: begin
        if (r_sync) begin
          w_state_nxt = WAIT_HIGH;
        end else begin
          w_state_nxt = IDLE_LOW;
        end
      end
      WAIT_HIGH: begin
        if (!r_sync) begin
          w_state_nxt = IDLE_LOW;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = IDLE_HIGH;
        end else begin
          w_state_nxt = WAIT_HIGH;
          w_cnt_nxt   = r_cnt + CNT_W'(1'b1);
        end
      end
      IDLE_HIGH: begin
        if (!r_sync) begin
          w_state_nxt = WAIT_LOW;
        end else begin
          w_state_nxt = IDLE_HIGH;
        end
      end
      WAIT_LOW: begin
        if (r_sync) begin
          w_state_nxt = IDLE_HIGH;
        end else if (r_cnt == CNT_MAX) begin
          w_state_nxt = IDLE_LOW;
        end else begin
          w_state_nxt = WAIT_LOW;
          w_cnt_nxt   = r_cnt + CNT_W'(1'b1);
        end
      end
      default: begin
        w_state_nxt = IDLE_LOW;
        w_cnt_nxt   = {CNT_W{1'b0}};
      end
    endcase
  end

  // Outputs from the transition being taken; bit 1 of the encoding is the level.
  always_comb begin
    w_level_nxt = w_state_nxt[1];
    w_rise_nxt  = (r_state == WAIT_HIGH) && (w_state_nxt == IDLE_HIGH);
    w_fall_nxt  = (r_state == WAIT_LOW)  && (w_state_nxt == IDLE_LOW);
  end

  // Registered outputs so the pulse coincides with the first cycle of the new level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_level <= w_level_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button conditioner: NUM_BUTTONS independent synchronize +
// debounce channels producing clean levels and single-cycle edge pulses.
module button_conditioner
  import button_pkg::*;
#(
  parameter int NUM_BUTTONS     = 2,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_100MHZ,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_rise,
  output logic [NUM_BUTTONS-1:0] btn_fall
);

  for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_chan (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_raw   (btn_raw[g]),
      .o_level (btn_level[g]),
      .o_rise  (btn_rise[g]),
      .o_fall  (btn_fall[g])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Randomized and directed bench for button_conditioner (D=4, 2 channels)
// against a sample-window reference model.
module tb_button_conditioner;

  localparam int NB = 2;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NB-1:0] btn_raw;
  logic [NB-1:0] btn_level;
  logic [NB-1:0] btn_rise;
  logic [NB-1:0] btn_fall;

  int vectors = 0;
  int errors  = 0;

  // Reference model: the FSM sees raw delayed by two edges; a channel's level
  // flips once its last D+1 seen samples all disagree with the current level.
  logic [NB-1:0] raw_q[$];
  logic [NB-1:0] seen_q[$];
  logic [NB-1:0] m_level, m_rise, m_fall;

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BUTTONS     (NB),
    .DEBOUNCE_CYCLES (D)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall)
  );

  task automatic model_reset();
    raw_q.delete();
    seen_q.delete();
    m_level = '0;
    m_rise  = '0;
    m_fall  = '0;
  endtask

  task automatic model_edge();
    logic [NB-1:0] s;
    bit            all_diff;
    s = (raw_q.size() >= 2) ? raw_q[raw_q.size()-2] : '0;
    raw_q.push_back(btn_raw);
    if (raw_q.size() > 2) void'(raw_q.pop_front());
    seen_q.push_back(s);
    if (seen_q.size() > D + 1) void'(seen_q.pop_front());
    m_rise = '0;
    m_fall = '0;
    for (int ch = 0; ch < NB; ch++) begin
      if (seen_q.size() == D + 1) begin
        all_diff = 1'b1;
        foreach (seen_q[j]) if (seen_q[j][ch] == m_level[ch]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[ch] = ~m_level[ch];
          if (m_level[ch]) m_rise[ch] = 1'b1;
          else             m_fall[ch] = 1'b1;
        end
      end
    end
  endtask

  // One clock edge; outputs are settled 1 time unit later.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_edge();
    else       model_reset();
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    btn_raw = '0;
    model_reset();
    #3;
    vectors++;
    if ({btn_level, btn_rise, btn_fall} !== 6'b0) begin
      errors++;
      $display("FAIL reset_async got=%b_%b_%b want=00_00_00", btn_level, btn_rise, btn_fall);
    end
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      vectors++;
      if ({btn_level, btn_rise, btn_fall} !== 6'b0) begin
        errors++;
        $display("FAIL reset_idle k=%0d got=%b_%b_%b want=00_00_00", k, btn_level, btn_rise, btn_fall);
      end
    end
  endtask

  task automatic test_press();
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      vectors++;
      if (btn_level[0] !== (k >= 6) || btn_rise[0] !== (k == 6) || btn_fall !== 2'b00) begin
        errors++;
        $display("FAIL press edge=%0d level=%b rise=%b fall=%b want level=%0d rise=%0d fall=00",
                 k, btn_level[0], btn_rise[0], btn_fall, (k >= 6), (k == 6));
      end
    end
  endtask

  task automatic test_release();
    btn_raw[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step();
      vectors++;
      if (btn_level[0] !== (k < 6) || btn_fall[0] !== (k == 6) || btn_rise !== 2'b00) begin
        errors++;
        $display("FAIL release edge=%0d level=%b fall=%b rise=%b want level=%0d fall=%0d rise=00",
                 k, btn_level[0], btn_fall[0], btn_rise, (k < 6), (k == 6));
      end
    end
  endtask

  task automatic test_bounce();
    for (int r = 0; r < 5; r++) begin
      for (int k = 0; k < 5; k++) begin
        btn_raw[0] = (k < 3);
        step();
        vectors++;
        if (btn_level[0] !== 1'b0 || btn_rise[0] !== 1'b0 || btn_fall[0] !== 1'b0) begin
          errors++;
          $display("FAIL bounce r=%0d k=%0d got=%b_%b_%b want=0_0_0", r, k, btn_level[0], btn_rise[0], btn_fall[0]);
        end
      end
    end
    btn_raw[0] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      vectors++;
      if (btn_level[0] !== 1'b0 || btn_rise[0] !== 1'b0 || btn_fall[0] !== 1'b0) begin
        errors++;
        $display("FAIL bounce_tail k=%0d got=%b_%b_%b want=0_0_0", k, btn_level[0], btn_rise[0], btn_fall[0]);
      end
    end
  endtask

  task automatic test_independence();
    int r0 = -1;
    int r1 = -1;
    for (int k = 0; k < 14; k++) begin
      btn_raw[0] = 1'b1;
      btn_raw[1] = (k >= 2);
      step();
      if (btn_rise[0] && r0 < 0) r0 = k;
      if (btn_rise[1] && r1 < 0) r1 = k;
    end
    vectors++;
    if (r0 !== 6 || r1 !== 8) begin
      errors++;
      $display("FAIL indep_rise rise0_edge=%0d rise1_edge=%0d want 6 and 8", r0, r1);
    end
    // Short low glitches on channel 1 while channel 0 holds high.
    for (int k = 0; k < 15; k++) begin
      btn_raw[1] = (k % 5) > 1;
      step();
      vectors++;
      if (btn_level !== 2'b11 || btn_rise !== 2'b00 || btn_fall !== 2'b00) begin
        errors++;
        $display("FAIL indep_glitch k=%0d got=%b_%b_%b want=11_00_00", k, btn_level, btn_rise, btn_fall);
      end
    end
    btn_raw = '0;
    for (int k = 0; k < 10; k++) begin
      step();
      vectors++;
      if ({btn_level, btn_rise, btn_fall} !== {m_level, m_rise, m_fall}) begin
        errors++;
        $display("FAIL indep_release k=%0d got=%b_%b_%b want=%b_%b_%b",
                 k, btn_level, btn_rise, btn_fall, m_level, m_rise, m_fall);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    btn_raw[0] = 1'b1;
    for (int k = 0; k < 5; k++) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({btn_level, btn_rise, btn_fall} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_async got=%b_%b_%b want=00_00_00", btn_level, btn_rise, btn_fall);
    end
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if ({btn_level, btn_rise, btn_fall} !== 6'b0) begin
        errors++;
        $display("FAIL midreset_hold k=%0d got=%b_%b_%b want=00_00_00", k, btn_level, btn_rise, btn_fall);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step();
      vectors++;
      if (btn_level[0] !== (k >= 6) || btn_rise[0] !== (k == 6) || btn_fall[0] !== 1'b0) begin
        errors++;
        $display("FAIL midreset_repress edge=%0d got=%b_%b_%b want=%0d_%0d_0",
                 k, btn_level[0], btn_rise[0], btn_fall[0], (k >= 6), (k == 6));
      end
    end
  endtask

  task automatic test_random();
    int hold[NB];
    for (int ch = 0; ch < NB; ch++) hold[ch] = 0;
    for (int k = 0; k < 800; k++) begin
      for (int ch = 0; ch < NB; ch++) begin
        if (hold[ch] == 0) begin
          btn_raw[ch] = 1'($urandom_range(1, 0));
          hold[ch]    = $urandom_range(9, 1);
        end
        hold[ch]--;
      end
      step();
      vectors++;
      if ({btn_level, btn_rise, btn_fall} !== {m_level, m_rise, m_fall}) begin
        errors++;
        $display("FAIL random k=%0d got=%b_%b_%b want=%b_%b_%b",
                 k, btn_level, btn_rise, btn_fall, m_level, m_rise, m_fall);
      end
    end
  endtask

  initial begin
    test_reset();
    test_press();
    test_release();
    test_bounce();
    test_independence();
    test_reset_mid_count();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
# button_conditioner

Input-conditioning stage between raw board push-buttons (or other mechanical/asynchronous level inputs) and the control FSMs that consume `restart`/`pause`-style commands. Per channel it synchronizes the raw input into the `clk` domain and debounces it. It outputs a clean level plus single-cycle rise and fall pulses. Downstream FSMs OR these levels with their VIO probes exactly as they would a pin input.

## Interface
Parameters:
- `NUM_BUTTONS`, default 2: number of independent channels (bit 0 = restart, bit 1 = pause in the lab top level).
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable cycles required before a change is accepted (10 ms at 100 MHz). Must be ≥ 1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width. Derived; not overridden.

Ports:
- `clk`, input, 1: single system clock. All logic is on its rising edge.
- `rst_n`, input, 1: reset, asynchronous assert, active-low.
- `btn_raw`, input, NUM_BUTTONS: raw asynchronous button levels, active-high.
- `btn_level`, output, NUM_BUTTONS: debounced level.
- `btn_rise`, output, NUM_BUTTONS: one-cycle pulse when `btn_level` goes 0→1.
- `btn_fall`, output, NUM_BUTTONS: one-cycle pulse when `btn_level` goes 1→0.

## Operation
- Each channel is fully independent and has identical logic.
- Synchronizer: two flops per channel, `sync1 <= btn_raw[i]`, `sync <= sync1`. Only `sync` is used downstream; `btn_raw` never drives logic directly.
- Per-channel FSM, 4 states:
  - IDLE_LOW: level 0. If `sync`=1, go to WAIT_HIGH and set cnt=0.
  - WAIT_HIGH: if `sync`=0, return to IDLE_LOW (bounce), clear cnt, no pulse. Else if cnt==DEBOUNCE_CYCLES-1, go to IDLE_HIGH. Otherwise cnt++.
  - IDLE_HIGH: level 1. If `sync`=0, go to WAIT_LOW and set cnt=0.
  - WAIT_LOW: mirror of WAIT_HIGH, returning to IDLE_HIGH on bounce and going to IDLE_LOW on expiry.
- `btn_level`, `btn_rise` and `btn_fall` are registered outputs:
  - `btn_level` changes on the edge that leaves WAIT_* by expiry.
  - `btn_rise`/`btn_fall` is high for exactly the one cycle following that edge.
  - A rise pulse and a fall pulse can never coincide on one channel.
- Counter arithmetic: unsigned CNT_W bits. It never exceeds DEBOUNCE_CYCLES-1, so it never wraps.
- Any glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change.
- Reset (`rst_n`=0, asynchronous), all channels:
  - sync flops = 0, cnt = 0, state = IDLE_LOW.
  - `btn_level` = 0, `btn_rise` = 0, `btn_fall` = 0.
  - An in-progress count is abandoned.
  - A button held through reset is debounced afresh after release and produces a rise pulse.
- Illegal state encoding: go to IDLE_LOW on the next edge with level 0 and no pulse.

## Timing
- Latency: `btn_level` changes D+2 rising edges after the edge that first samples the new `btn_raw` value (D = DEBOUNCE_CYCLES): 2 synchronizer edges, 1 IDLE→WAIT edge, D−1 count edges.
- Pulse width is exactly 1 cycle and is coincident with the first cycle of the new level.
- Minimum accepted press or release duration is D+1 consecutive identical `sync` samples, counting from the IDLE→WAIT edge.
- Reset deassertion is assumed synchronized externally. The first FSM action happens on the first `clk` edge with `rst_n`=1.

## Structure
- Shared package `button_pkg` holds:
  - the state encoding localparams IDLE_LOW=2'b00, WAIT_HIGH=2'b01, IDLE_HIGH=2'b11, WAIT_LOW=2'b10;
  - the default DEBOUNCE_CYCLES constant for 100 MHz.
- Sub-module `debounce_channel`: the synchronizer, counter, FSM and pulse registers for one bit, with parameter DEBOUNCE_CYCLES.
- `button_conditioner` is a generate loop of NUM_BUTTONS `debounce_channel` instances.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and NUM_BUTTONS=2.
- Reset, then hold `btn_raw`=2'b00 for 20 cycles → `btn_level`/`btn_rise`/`btn_fall` all stay 0.
- `btn_raw[0]` 0→1 sampled at edge 0 and held → `btn_level[0]`=1 after edge 6; `btn_rise[0]`=1 only in the cycle after edge 6; `btn_fall`=0 throughout.
- Bounce: `btn_raw[0]` high for 3 cycles, low for 2, repeated 5 times, then low → `btn_level[0]` stays 0 and no pulses occur.
- Release: from level 1, `btn_raw[0]` 1→0 at edge 0 and held → `btn_level[0]`=0 after edge 6 with a single-cycle `btn_fall[0]`.
- Independence: `btn_raw[1]` rises 2 cycles after `btn_raw[0]` → `btn_rise[1]` occurs exactly 2 cycles after `btn_rise[0]`; a bounce on channel 1 leaves channel 0 unaffected.
- Reset mid-count: `rst_n` low at edge 4 of a press → all outputs are 0 immediately, with no pulse. With `btn_raw[0]` still 1 after `rst_n` releases, `btn_level[0]` rises 6 edges after the first post-reset edge, with a rise pulse.
